// File: rtl/axi_burst_rd_responder.sv
// AXI4 read-channel responder serving single and INCR/FIXED bursts from a
// word-addressed on-chip memory, with a side port for preload/update writes.
module axi_burst_rd_responder #(
  parameter int          MEM_DEPTH    = 1024,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  araddr,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  output logic [31:0]                  rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  output logic                         rlast,
  input  logic                         rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [31:0]                  mem_wdata
);

  localparam int          AW       = $clog2(MEM_DEPTH);
  localparam int          LW       = $clog2(READ_LATENCY + 2);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_DEPTH) << 2);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  logic [31:0]   mem [MEM_DEPTH];

  state_t        state_reg;
  logic [AW-1:0] idx_reg;
  logic [7:0]    len_reg;
  logic [7:0]    cnt_reg;
  logic          fixed_reg;
  logic [1:0]    resp_reg;
  logic [LW-1:0] lat_reg;
  logic          arready_reg;
  logic          rvalid_reg;
  logic          rlast_reg;
  logic [31:0]   rdata_reg;

  logic [AW-1:0] ar_idx;
  logic [1:0]    ar_resp;
  logic          accept;
  logic          beat_hs;
  logic [AW-1:0] next_idx;
  logic          load_beat;
  logic          load_err;
  logic [AW-1:0] rd_idx;

  assign ar_idx   = AW'((araddr - BASE_ADDR) >> 2);
  assign accept   = (state_reg == IDLE) && arvalid && arready_reg;
  assign beat_hs  = (state_reg == BEAT) && rvalid_reg && rready;
  // Index width equals log2(MEM_DEPTH), so +1 wraps to word 0 on its own.
  assign next_idx = fixed_reg ? idx_reg : idx_reg + AW'(1);

  // Error class is fixed once at acceptance and replayed on every beat.
  always_comb begin
    ar_resp = 2'b00;
    if (({1'b0, araddr} < {1'b0, BASE_ADDR}) || ({1'b0, araddr} >= END_ADDR))
      ar_resp = 2'b11;
    else if ((arsize != 3'b010) || arburst[1] || (araddr[1:0] != 2'b00))
      ar_resp = 2'b10;
  end

  // Single read site: the fetch address depends on which event presents a beat.
  always_comb begin
    load_beat = 1'b0;
    load_err  = (resp_reg != 2'b00);
    rd_idx    = idx_reg;
    if (accept && (READ_LATENCY == 0)) begin
      load_beat = 1'b1;
      load_err  = (ar_resp != 2'b00);
      rd_idx    = ar_idx;
    end else if ((state_reg == WAIT) && (lat_reg == LW'(1))) begin
      load_beat = 1'b1;
    end else if (beat_hs && !rlast_reg) begin
      load_beat = 1'b1;
      rd_idx    = next_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      fixed_reg   <= 1'b0;
      resp_reg    <= 2'b00;
      lat_reg     <= '0;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      if (load_beat)
        rdata_reg <= load_err ? 32'h0 : mem[rd_idx];
      case (state_reg)
        IDLE: begin
          if (accept) begin
            idx_reg     <= ar_idx;
            len_reg     <= arlen;
            cnt_reg     <= '0;
            fixed_reg   <= (arburst == 2'b00);
            resp_reg    <= ar_resp;
            arready_reg <= 1'b0;
            if (READ_LATENCY == 0) begin
              state_reg  <= BEAT;
              rvalid_reg <= 1'b1;
              rlast_reg  <= (arlen == 8'd0);
            end else begin
              state_reg <= WAIT;
              lat_reg   <= LW'(READ_LATENCY);
            end
          end
        end
        WAIT: begin
          lat_reg <= lat_reg - LW'(1);
          if (lat_reg == LW'(1)) begin
            state_reg  <= BEAT;
            rvalid_reg <= 1'b1;
            rlast_reg  <= (len_reg == 8'd0);
          end
        end
        BEAT: begin
          if (beat_hs) begin
            if (rlast_reg) begin
              state_reg   <= IDLE;
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
            end else begin
              cnt_reg   <= cnt_reg + 8'd1;
              idx_reg   <= next_idx;
              rlast_reg <= ((cnt_reg + 8'd1) == len_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign arready = arready_reg;
  assign rvalid  = rvalid_reg;
  assign rlast   = rlast_reg;
  assign rdata   = rdata_reg;
  assign rresp   = resp_reg;

endmodule

// File: tb/tb_axi_burst_rd_responder.sv
// Directed bench: expected beats are queued at issue time and popped by a
// negedge monitor on every R-channel handshake.
module tb_axi_burst_rd_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = 3'b010;
  logic [1:0]    arburst = 2'b01;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rlast;
  logic          rready = 1'b1;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [31:0]   mem_wdata = '0;

  axi_burst_rd_responder #(.MEM_DEPTH(DEPTH), .READ_LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    toggle_mode = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // rready pattern 1,0,0,1 when toggling, otherwise tied high.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clock);
      #1;
      if (toggle_mode) begin
        rready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        rready = 1'b1;
      end
    end
  end

  // Monitor: pops on handshake, checks that a stalled beat stays put.
  initial begin
    bit    held_v = 1'b0;
    beat_t held;
    beat_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v && rvalid) begin
          check("hold_rdata", rdata, held.data);
          check("hold_rresp", {30'd0, rresp}, {30'd0, held.resp});
          check("hold_rlast", {31'd0, rlast}, {31'd0, held.last});
        end
        if (rvalid && rready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", rdata, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", {30'd0, rresp}, {30'd0, e.resp});
            check("rlast", {31'd0, rlast}, {31'd0, e.last});
            $display("beat data=0x%08h resp=%0d last=%0d", rdata, rresp, rlast);
          end
        end else if (rvalid) begin
          held_v = 1'b1;
          held   = '{rdata, rresp, rlast};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    mem_we = 1'b1;
    mem_waddr = AW'(idx);
    mem_wdata = d;
    sync();
    mem_we = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_q.push_back('{d, r, l});
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b, output int k);
    bit ok = 1'b0;
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    sync();
    k = cyc;
    arvalid = 1'b0;
    $display("request addr=0x%08h len=%0d size=%0d burst=%0d accepted at cycle %0d", a, l, s, b, k);
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && arready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'(exp_q.size()), 32'd0);
    sync();
  endtask

  initial begin
    int k;
    bit seen;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_arready", {31'd0, arready}, 32'd1);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rlast",   {31'd0, rlast},   32'd0);
    check("rst_rresp",   {30'd0, rresp},   32'd0);
    check("rst_rdata",   rdata,            32'd0);
    sync();
    reset = 1'b0;

    wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44);
    wr(5, 32'hABCD);
    wr(DEPTH - 2, 32'hC0DE_03FE); wr(DEPTH - 1, 32'hC0DE_03FF);

    // 4-beat INCR, rready high: latency and occupancy
    push(32'h11, 2'b00, 1'b0); push(32'h22, 2'b00, 1'b0);
    push(32'h33, 2'b00, 1'b0); push(32'h44, 2'b00, 1'b1);
    issue(32'h8000_0000, 8'd3, 3'b010, 2'b01, k);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rvalid) begin seen = 1'b1; break; end
    end
    check("first_rvalid_cycle", seen ? 32'(cyc - k) : 32'hFFFF_FFFF, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    check("arready_back_cycle", seen ? 32'(cyc - k) : 32'hFFFF_FFFF, 32'd6);
    drain("drain_incr");

    // same burst with backpressure
    toggle_mode = 1'b1;
    push(32'h11, 2'b00, 1'b0); push(32'h22, 2'b00, 1'b0);
    push(32'h33, 2'b00, 1'b0); push(32'h44, 2'b00, 1'b1);
    issue(32'h8000_0000, 8'd3, 3'b010, 2'b01, k);
    drain("drain_toggle");
    toggle_mode = 1'b0;
    sync();

    // INCR wrapping past the last word
    push(32'hC0DE_03FE, 2'b00, 1'b0); push(32'hC0DE_03FF, 2'b00, 1'b0);
    push(32'h11, 2'b00, 1'b0);        push(32'h22, 2'b00, 1'b1);
    issue(32'h8000_0000 + 32'(4 * (DEPTH - 2)), 8'd3, 3'b010, 2'b01, k);
    drain("drain_wrap");

    // decode error below the window
    push(32'h0, 2'b11, 1'b0); push(32'h0, 2'b11, 1'b1);
    issue(32'h0000_1000, 8'd1, 3'b010, 2'b01, k);
    drain("drain_decerr");

    // decode error just past the window
    push(32'h0, 2'b11, 1'b1);
    issue(32'h8000_0000 + 32'(4 * DEPTH), 8'd0, 3'b010, 2'b01, k);
    drain("drain_decerr_top");

    // unsupported beat size
    push(32'h0, 2'b10, 1'b0); push(32'h0, 2'b10, 1'b1);
    issue(32'h8000_0000, 8'd1, 3'b011, 2'b01, k);
    drain("drain_slverr");

    // FIXED burst repeats one word
    push(32'hABCD, 2'b00, 1'b0); push(32'hABCD, 2'b00, 1'b0); push(32'hABCD, 2'b00, 1'b1);
    issue(32'h8000_0014, 8'd2, 3'b010, 2'b00, k);
    drain("drain_fixed");

    // reset while beat 2 is presented abandons the burst
    push(32'h11, 2'b00, 1'b0);
    issue(32'h8000_0000, 8'd3, 3'b010, 2'b01, k);
    for (int i = 0; i < 20 && cyc < k + 3; i++) sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_rvalid",  {31'd0, rvalid},  32'd0);
    check("midrst_arready", {31'd0, arready}, 32'd1);
    check("midrst_rlast",   {31'd0, rlast},   32'd0);
    sync();
    repeat (4) @(negedge clock);
    check("midrst_no_more_beats", {31'd0, rvalid}, 32'd0);
    sync();

    // fresh single-beat request after reset
    push(32'h44, 2'b00, 1'b1);
    issue(32'h8000_000C, 8'd0, 3'b010, 2'b01, k);
    drain("drain_single");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
